// File: rtl/i2c_ram_arbiter.sv
// Single-port RAM arbiter between the I2C slave engine and the menu controller,
// with a hardware clear sweep. All RAM-side and requester-side outputs are registered.
//
// state  | meaning
// IDLE   | arbitrate: pending clear, forced menu, slave, menu
// ACCESS | RAM acts on the registered address/data, write enable dropped
// RDWAIT | RAM read data valid; capture for reads, pulse owner ack
// DONE   | dead cycle while the requester drops its request
// CLEAR  | write 0x00 to 0..CLR_LAST, one address per cycle
module i2c_ram_arbiter #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 8,
  parameter int CLR_LAST      = 255,
  parameter int MENU_MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              slv_req,
  input  logic              slv_we,
  input  logic [ADDR_W-1:0] slv_addr,
  input  logic [DATA_W-1:0] slv_din,
  output logic              slv_ack,
  output logic [DATA_W-1:0] slv_dout,
  input  logic              menu_req,
  input  logic              menu_we,
  input  logic [ADDR_W-1:0] menu_addr,
  input  logic [DATA_W-1:0] menu_din,
  output logic              menu_ack,
  output logic [DATA_W-1:0] menu_dout,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [2:0] {IDLE, ACCESS, RDWAIT, DONE, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] CLR_LAST_A = ADDR_W'(CLR_LAST);
  localparam logic [3:0]        MAX_WAIT   = 4'(MENU_MAX_WAIT);

  state_t              state_q, state_d;
  logic                owner_menu_q, owner_menu_d;
  logic                owner_we_q, owner_we_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic                clr_pend_q, clr_pend_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic                ram_we_q, ram_we_d;
  logic                slv_ack_q, slv_ack_d;
  logic                menu_ack_q, menu_ack_d;
  logic [DATA_W-1:0]   slv_dout_q, slv_dout_d;
  logic [DATA_W-1:0]   menu_dout_q, menu_dout_d;
  logic                force_menu;
  logic                grant_menu;

  assign force_menu = menu_req && (wait_cnt_q == MAX_WAIT);
  assign grant_menu = force_menu || (menu_req && !slv_req);
  assign clr_busy   = clr_pend_q || (state_q == CLEAR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_menu_q <= 1'b0;
      owner_we_q   <= 1'b0;
      wait_cnt_q   <= '0;
      clr_pend_q   <= 1'b0;
      clr_cnt_q    <= '0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      ram_we_q     <= 1'b0;
      slv_ack_q    <= 1'b0;
      menu_ack_q   <= 1'b0;
      slv_dout_q   <= '0;
      menu_dout_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_menu_q <= owner_menu_d;
      owner_we_q   <= owner_we_d;
      wait_cnt_q   <= wait_cnt_d;
      clr_pend_q   <= clr_pend_d;
      clr_cnt_q    <= clr_cnt_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      ram_we_q     <= ram_we_d;
      slv_ack_q    <= slv_ack_d;
      menu_ack_q   <= menu_ack_d;
      slv_dout_q   <= slv_dout_d;
      menu_dout_q  <= menu_dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (clr_pend_q)               state_d = CLEAR;
        else if (slv_req || menu_req) state_d = ACCESS;
      end
      ACCESS: state_d = RDWAIT;
      RDWAIT: state_d = DONE;
      DONE:   state_d = IDLE;
      CLEAR:  if (clr_cnt_q == CLR_LAST_A) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_menu_d = owner_menu_q;
    owner_we_d   = owner_we_q;
    wait_cnt_d   = wait_cnt_q;
    clr_pend_d   = clr_pend_q;
    clr_cnt_d    = clr_cnt_q;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    ram_we_d     = 1'b0;
    slv_ack_d    = 1'b0;
    menu_ack_d   = 1'b0;
    slv_dout_d   = slv_dout_q;
    menu_dout_d  = menu_dout_q;

    if (clr_req && !clr_busy) clr_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (!menu_req) wait_cnt_d = '0;
        if (!clr_pend_q) begin
          if (grant_menu) begin
            owner_menu_d = 1'b1;
            owner_we_d   = menu_we;
            ram_addr_d   = menu_addr;
            ram_din_d    = menu_din;
            ram_we_d     = menu_we;
            wait_cnt_d   = '0;
          end else if (slv_req) begin
            owner_menu_d = 1'b0;
            owner_we_d   = slv_we;
            ram_addr_d   = slv_addr;
            ram_din_d    = slv_din;
            ram_we_d     = slv_we;
            if (menu_req && wait_cnt_q != MAX_WAIT) wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end
      end
      RDWAIT: begin
        if (owner_menu_q) begin
          menu_ack_d = 1'b1;
          if (!owner_we_q) menu_dout_d = ram_dout;
        end else begin
          slv_ack_d = 1'b1;
          if (!owner_we_q) slv_dout_d = ram_dout;
        end
      end
      CLEAR: begin
        ram_addr_d = clr_cnt_q;
        ram_din_d  = '0;
        ram_we_d   = 1'b1;
        if (clr_cnt_q == CLR_LAST_A) begin
          clr_cnt_d  = '0;
          clr_pend_d = 1'b0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_we    = ram_we_q;
  assign slv_ack   = slv_ack_q;
  assign menu_ack  = menu_ack_q;
  assign slv_dout  = slv_dout_q;
  assign menu_dout = menu_dout_q;

endmodule

// File: tb/tb_i2c_ram_arbiter.sv
// Directed bench for i2c_ram_arbiter with a behavioural synchronous RAM.
module tb_i2c_ram_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       slv_req = 0, slv_we = 0, menu_req = 0, menu_we = 0, clr_req = 0;
  logic [7:0] slv_addr = 0, slv_din = 0, menu_addr = 0, menu_din = 0;
  logic       slv_ack, menu_ack, clr_busy, ram_we;
  logic [7:0] slv_dout, menu_dout, ram_addr, ram_din;
  logic [7:0] ram_dout = 8'h00;
  logic [7:0] mem [256] = '{default: 8'h00};

  int n_assert = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  logic [7:0] log_addr [1024];
  logic [7:0] log_data [1024];
  int ack_both = 0;
  int ack_wide = 0;
  logic prev_s = 0, prev_m = 0;

  i2c_ram_arbiter dut (
    .clk(clk), .reset(rst_n),
    .slv_req(slv_req), .slv_we(slv_we), .slv_addr(slv_addr), .slv_din(slv_din),
    .slv_ack(slv_ack), .slv_dout(slv_dout),
    .menu_req(menu_req), .menu_we(menu_we), .menu_addr(menu_addr), .menu_din(menu_din),
    .menu_ack(menu_ack), .menu_dout(menu_dout),
    .clr_req(clr_req), .clr_busy(clr_busy),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      if (wr_cnt < 1024) begin
        log_addr[wr_cnt] <= ram_addr;
        log_data[wr_cnt] <= ram_din;
      end
      wr_cnt <= wr_cnt + 1;
    end
    ram_dout <= mem[ram_addr];
    if (slv_ack && menu_ack) ack_both <= ack_both + 1;
    if ((slv_ack && prev_s) || (menu_ack && prev_m)) ack_wide <= ack_wide + 1;
    prev_s <= slv_ack;
    prev_m <= menu_ack;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic access(input bit is_menu, input bit we, input logic [7:0] addr,
                        input logic [7:0] din, output int lat);
    if (is_menu) begin
      menu_req = 1; menu_we = we; menu_addr = addr; menu_din = din;
    end else begin
      slv_req = 1; slv_we = we; slv_addr = addr; slv_din = din;
    end
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(is_menu ? menu_ack : slv_ack) && lat < 20);
    menu_req = 0;
    slv_req = 0;
    tick();
  endtask

  initial begin
    int lat, t, ts, tm, nacks, last, bad, w0, wc, acks_busy;
    logic [4:0] seq;

    repeat (3) tick();
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_clr_busy", clr_busy, 0);
    check("rst_acks", {slv_ack, menu_ack}, 0);
    rst_n = 1;
    tick();

    // slave write 0xA5 to 0x10, stepped to watch the RAM bus
    slv_req = 1; slv_we = 1; slv_addr = 8'h10; slv_din = 8'hA5;
    tick();
    check("wr_ram_we_n", ram_we, 1);
    check("wr_ram_addr", ram_addr, 8'h10);
    check("wr_ram_din", ram_din, 8'hA5);
    tick();
    check("wr_ram_we_n1", ram_we, 0);
    check("wr_ack_early", slv_ack, 0);
    tick();
    check("wr_ack_n2", slv_ack, 1);
    slv_req = 0;
    tick();
    check("wr_ack_width", slv_ack, 0);
    check("wr_count", wr_cnt, 1);
    check("wr_mem", mem[8'h10], 8'hA5);

    access(0, 0, 8'h10, 8'h00, lat);
    check("rd_latency", lat, 3);
    check("rd_dout", slv_dout, 8'hA5);
    check("rd_no_write", wr_cnt, 1);

    // simultaneous requests: slave wins, menu follows 4 cycles later
    slv_req = 1; slv_we = 0; slv_addr = 8'h01;
    menu_req = 1; menu_we = 1; menu_addr = 8'h02; menu_din = 8'h3C;
    ts = 0; tm = 0; t = 0;
    while ((ts == 0 || tm == 0) && t < 30) begin
      tick();
      t++;
      if (slv_ack)  begin ts = t; slv_req = 0; end
      if (menu_ack) begin tm = t; menu_req = 0; end
    end
    tick();
    check("sim_slv_ack_t", ts, 3);
    check("sim_menu_ack_t", tm, 7);
    check("sim_slv_dout", slv_dout, 8'h00);
    check("sim_menu_mem", mem[8'h02], 8'h3C);

    // slave hogging: menu forced in after three slave slots
    slv_req = 1; slv_we = 0; slv_addr = 8'h02;
    menu_req = 1; menu_we = 0; menu_addr = 8'h10;
    seq = '0; nacks = 0; t = 0; last = 0; bad = 0;
    while (nacks < 5 && t < 60) begin
      tick();
      t++;
      if (slv_ack || menu_ack) begin
        seq = {seq[3:0], menu_ack};
        if (nacks > 0 && (t - last) != 4) bad++;
        last = t;
        nacks++;
        if (menu_ack) menu_req = 0;
      end
    end
    slv_req = 0;
    tick();
    check("fair_nacks", nacks, 5);
    check("fair_seq", seq, 5'b00010);
    check("fair_period", bad, 0);
    check("fair_slv_dout", slv_dout, 8'h3C);
    check("fair_menu_dout", menu_dout, 8'hA5);

    // clear requested during a slave write
    slv_req = 1; slv_we = 1; slv_addr = 8'h20; slv_din = 8'h55;
    tick();
    check("clr_acc_we", ram_we, 1);
    clr_req = 1;
    tick();
    clr_req = 0;
    check("clr_busy_rise", clr_busy, 1);
    tick();
    check("clr_acc_ack", slv_ack, 1);
    slv_req = 0;
    w0 = wr_cnt;
    t = 0;
    while (clr_busy && t < 400) begin
      tick();
      t++;
    end
    check("clr_busy_dur", t, 258);
    check("clr_last_bus", {ram_we, ram_addr}, {1'b1, 8'hFF});
    tick();
    check("clr_we_off", ram_we, 0);
    check("clr_nwrites", wr_cnt - w0, 256);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (w0 + i < 1024)
        if (log_addr[w0 + i] != 8'(i) || log_data[w0 + i] != 8'h00) bad++;
    check("clr_sweep_seq", bad, 0);
    check("clr_acc_mem_gone", mem[8'h20], 8'h00);
    access(1, 0, 8'h10, 8'h00, lat);
    check("clr_menu_rd_lat", lat, 3);
    check("clr_menu_rd_dout", menu_dout, 8'h00);

    // reset mid-sweep
    clr_req = 1;
    tick();
    clr_req = 0;
    check("rsw_busy", clr_busy, 1);
    t = 0;
    while (!(ram_we && ram_addr == 8'h40) && t < 200) begin
      tick();
      t++;
    end
    check("rsw_at_40", {ram_we, ram_addr}, {1'b1, 8'h40});
    wc = wr_cnt;
    rst_n = 0;
    #1;
    check("rsw_ram_we", ram_we, 0);
    check("rsw_ram_addr", ram_addr, 0);
    check("rsw_ram_din", ram_din, 0);
    check("rsw_acks", {slv_ack, menu_ack}, 0);
    check("rsw_slv_dout", slv_dout, 0);
    check("rsw_menu_dout", menu_dout, 0);
    check("rsw_busy0", clr_busy, 0);
    tick();
    tick();
    rst_n = 1;
    repeat (10) tick();
    check("rsw_no_writes", wr_cnt - wc, 0);
    check("rsw_busy_after", clr_busy, 0);
    access(0, 0, 8'h30, 8'h00, lat);
    check("rsw_idle_lat", lat, 3);

    // second clear while busy is ignored; slave request waits out the sweep
    clr_req = 1;
    tick();
    clr_req = 0;
    w0 = wr_cnt;
    repeat (5) tick();
    clr_req = 1;
    tick();
    clr_req = 0;
    slv_req = 1; slv_we = 1; slv_addr = 8'h05; slv_din = 8'h99;
    acks_busy = 0; t = 0;
    while (clr_busy && t < 400) begin
      tick();
      t++;
      if (slv_ack || menu_ack) acks_busy++;
    end
    check("dbl_no_ack_busy", acks_busy, 0);
    t = 0;
    while (!slv_ack && t < 20) begin
      tick();
      t++;
    end
    check("dbl_ack_after", t, 3);
    slv_req = 0;
    repeat (12) tick();
    check("dbl_nwrites", wr_cnt - w0, 257);
    check("dbl_busy_after", clr_busy, 0);
    check("dbl_mem5", mem[8'h05], 8'h99);

    check("ack_overlap", ack_both, 0);
    check("ack_width", ack_wide, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
